// File: rtl/servo_pkg.sv
// Shared constants, FSM state encoding and the pulse-width clamp helper
// for the multi-channel servo ramp controller.
package servo_pkg;

  localparam int NCH_DEF       = 5;
  localparam int PERIOD_DEF    = 2000000;
  localparam int PW_MIN_DEF    = 100000;
  localparam int PW_MAX_DEF    = 200000;
  localparam int PW_CENTER_DEF = 150000;
  localparam int STEP_DEF      = 2000;

  localparam logic [2:0] CTRL_ADDR = 3'd7;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  function automatic logic [31:0] clamp_pw(input logic [31:0] val,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Configuration bus plus servo write/status signals of the ramp controller.
// The master drives configuration; the slave is the controller itself.
interface servo_ramp_ctrl_if #(
  parameter int NCH = servo_pkg::NCH_DEF
);
  logic           cfg_write;
  logic [2:0]     cfg_addr;
  logic [31:0]    cfg_data;
  logic [NCH-1:0] servo_write;
  logic [31:0]    servo_data;
  logic [NCH-1:0] at_target;
  logic           busy;

  modport master (
    output cfg_write, cfg_addr, cfg_data,
    input  servo_write, servo_data, at_target, busy
  );

  modport slave (
    input  cfg_write, cfg_addr, cfg_data,
    output servo_write, servo_data, at_target, busy
  );
endinterface

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter; tick is high for the last cycle of
// every PERIOD-cycle frame.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic PCLK,
  input  logic PRESET,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(PERIOD - 1));

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge PCLK) begin
    if (PRESET)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CW'(1);
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo ramp controller: on each frame tick, walks every
// channel once and moves its pulse width at most STEP toward its target.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int PW_MIN    = PW_MIN_DEF,
  parameter int PW_MAX    = PW_MAX_DEF,
  parameter int PW_CENTER = PW_CENTER_DEF,
  parameter int STEP      = STEP_DEF
) (
  input logic              PCLK,
  input logic              PRESET,
  servo_ramp_ctrl_if.slave bus
);

  localparam int              IW          = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0]   LAST_IDX    = IW'(NCH - 1);
  localparam logic [31:0]     STEP_W      = 32'(STEP);
  localparam logic [31:0]     PW_MIN_W    = 32'(PW_MIN);
  localparam logic [31:0]     PW_MAX_W    = 32'(PW_MAX);
  localparam logic [31:0]     PW_CENTER_W = 32'(PW_CENTER);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            enable_q;
  logic [31:0]     target_q [NCH];
  logic [31:0]     cur_q    [NCH];
  logic [NCH-1:0]  servo_write_q;
  logic [31:0]     servo_data_q;
  logic [NCH-1:0]  at_target;
  logic            tick;

  logic [31:0]     cur_sel, tgt_sel, next_val, wr_val;
  logic            issue;

  servo_frame_timer #(.PERIOD(PERIOD)) u_frame_timer (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .tick   (tick)
  );

  // The visit reads the registered target, so a same-cycle target write
  // only lands in the array after this visit has been decided.
  assign cur_sel = cur_q[idx_q];
  assign tgt_sel = target_q[idx_q];

  always_comb begin
    next_val = cur_sel;
    if (cur_sel < tgt_sel)
      next_val = ((tgt_sel - cur_sel) > STEP_W) ? cur_sel + STEP_W : tgt_sel;
    else if (cur_sel > tgt_sel)
      next_val = ((cur_sel - tgt_sel) > STEP_W) ? cur_sel - STEP_W : tgt_sel;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    issue   = 1'b0;
    wr_val  = next_val;
    case (state_q)
      ST_INIT: begin
        issue  = 1'b1;
        wr_val = PW_CENTER_W;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_IDLE: begin
        if (tick && enable_q) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end
      end
      ST_UPDATE: begin
        issue = (next_val != cur_sel);
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: target and cur arrays are reset element by element because their
  // reset value is architecturally visible; plain storage would be left unreset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      enable_q      <= 1'b1;
      servo_write_q <= '0;
      servo_data_q  <= '0;
      for (int k = 0; k < NCH; k++) begin
        target_q[k] <= PW_CENTER_W;
        cur_q[k]    <= PW_CENTER_W;
      end
    end else begin
      servo_write_q <= issue ? (NCH'(1) << idx_q) : '0;
      if (issue) begin
        servo_data_q <= wr_val;
        cur_q[idx_q] <= wr_val;
      end
      if (bus.cfg_write) begin
        if (bus.cfg_addr == CTRL_ADDR)
          enable_q <= bus.cfg_data[0];
        else if (int'(bus.cfg_addr) < NCH)
          target_q[IW'(bus.cfg_addr)] <= clamp_pw(bus.cfg_data, PW_MIN_W, PW_MAX_W);
      end
    end
  end

  always_comb begin
    at_target = '0;
    for (int k = 0; k < NCH; k++) at_target[k] = (cur_q[k] == target_q[k]);
  end

  assign bus.servo_write = servo_write_q;
  assign bus.servo_data  = servo_data_q;
  assign bus.at_target   = at_target;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with short frames: a per-cycle strobe
// checker against an expected-write map, plus a clamp vector table.
module tb_servo_ramp_ctrl;

  localparam int NCH    = 5;
  localparam int PERIOD = 100;
  localparam int STEP   = 2000;

  logic PCLK;
  logic PRESET;
  int   cyc;
  bit   mon_en;
  int   n_cmp;
  int   n_err;

  logic [NCH-1:0] exp_wr  [int];
  logic [31:0]    exp_dat [int];
  logic [31:0]    last_data;

  typedef struct {
    logic [2:0]     addr;
    logic [31:0]    data;
    logic [NCH-1:0] exp_at;
  } vec_t;

  vec_t vecs [13];

  servo_ramp_ctrl_if #(.NCH(NCH)) bus ();

  servo_ramp_ctrl #(
    .NCH    (NCH),
    .PERIOD (PERIOD),
    .STEP   (STEP)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Cycle index since the last reset edge; frame f ticks in cycle 100f+99.
  always @(posedge PCLK) begin
    if (PRESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int c, input int ch, input logic [31:0] d);
    exp_wr[c]  = NCH'(1) << ch;
    exp_dat[c] = d;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge PCLK);
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
    bus.cfg_write = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_data  = d;
    @(negedge PCLK);
    bus.cfg_write = 1'b0;
  endtask

  // Every monitored cycle: either exactly the expected strobe/value, or no
  // strobe with servo_data holding the last written value.
  always @(negedge PCLK) begin
    if (mon_en) begin
      if (cyc == 0) last_data = '0;
      if (exp_wr.exists(cyc)) begin
        check($sformatf("servo_write@cyc%0d", cyc), 32'(bus.servo_write), 32'(exp_wr[cyc]));
        check($sformatf("servo_data@cyc%0d", cyc), bus.servo_data, exp_dat[cyc]);
        last_data = exp_dat[cyc];
      end else if (bus.servo_write !== '0 || bus.servo_data !== last_data) begin
        check($sformatf("idle_write@cyc%0d", cyc), 32'(bus.servo_write), 32'd0);
        check($sformatf("held_data@cyc%0d", cyc), bus.servo_data, last_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    mon_en = 1'b0;
    last_data = '0;
    PRESET = 1'b1;
    bus.cfg_write = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;

    vecs[0]  = '{3'd0, 32'd5000,       5'b11111};
    vecs[1]  = '{3'd0, 32'd0,          5'b11111};
    vecs[2]  = '{3'd0, 32'd100001,     5'b11110};
    vecs[3]  = '{3'd0, 32'd99999,      5'b11111};
    vecs[4]  = '{3'd4, 32'd999999,     5'b11111};
    vecs[5]  = '{3'd4, 32'd199999,     5'b01111};
    vecs[6]  = '{3'd4, 32'hFFFF_FFFF,  5'b11111};
    vecs[7]  = '{3'd3, 32'd150000,     5'b10111};
    vecs[8]  = '{3'd5, 32'd160000,     5'b10111};
    vecs[9]  = '{3'd6, 32'd0,          5'b10111};
    vecs[10] = '{3'd3, 32'd160000,     5'b11111};
    vecs[11] = '{3'd2, 32'd200001,     5'b11011};
    vecs[12] = '{3'd2, 32'd156000,     5'b11111};

    // Reset state, then the INIT sweep of centre writes.
    repeat (3) @(negedge PCLK);
    for (int k = 0; k < NCH; k++) expect_wr(1 + k, k, 32'd150000);
    PRESET = 1'b0;
    mon_en = 1'b1;
    check("reset_write", 32'(bus.servo_write), 32'd0);
    check("reset_data", bus.servo_data, 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd1);
    check("reset_at_target", 32'(bus.at_target), 32'h1F);
    wait_cyc(6);
    check("init_done_busy", 32'(bus.busy), 32'd0);

    // ch2 ramps 150000 -> 156000 over three frames, strobing at T+4.
    wait_cyc(10);
    cfg_wr(3'd2, 32'd156000);
    expect_wr(103, 2, 32'd152000);
    expect_wr(203, 2, 32'd154000);
    expect_wr(303, 2, 32'd156000);
    wait_cyc(20);
    check("ch2_not_at_target", 32'(bus.at_target), 32'b11011);
    wait_cyc(310);
    check("ch2_at_target", 32'(bus.at_target), 32'h1F);

    // Disabled for ticks 399/499/599, re-enabled before tick 699.
    wait_cyc(320);
    cfg_wr(3'd3, 32'd160000);
    wait_cyc(330);
    cfg_wr(3'd7, 32'd0);
    wait_cyc(600);
    check("ch3_held_while_disabled", 32'(bus.at_target), 32'b10111);
    check("idle_while_disabled", 32'(bus.busy), 32'd0);
    wait_cyc(610);
    cfg_wr(3'd7, 32'd1);
    for (int i = 0; i < 5; i++) expect_wr(704 + 100 * i, 3, 32'd152000 + 32'd2000 * 32'(i));

    // ch1 target written in its own visit cycle: effective one frame later.
    expect_wr(902, 1, 32'd152000);
    wait_cyc(801);
    check("update_busy", 32'(bus.busy), 32'd1);
    cfg_wr(3'd1, 32'd152000);
    wait_cyc(1105);
    check("all_at_target_1105", 32'(bus.at_target), 32'h1F);

    // Clamped extremes: ch0 down to PW_MIN, ch4 up to PW_MAX.
    wait_cyc(1110);
    cfg_wr(3'd0, 32'd5000);
    cfg_wr(3'd4, 32'd999999);
    check("extremes_pending", 32'(bus.at_target), 32'b01110);
    for (int f = 11; f <= 35; f++) begin
      expect_wr(100 * f + 101, 0, 32'd150000 - 32'd2000 * 32'(f - 10));
      expect_wr(100 * f + 105, 4, 32'd150000 + 32'd2000 * 32'(f - 10));
    end
    wait_cyc(3650);
    check("extremes_reached", 32'(bus.at_target), 32'h1F);

    // Clamp table with ramping frozen.
    cfg_wr(3'd7, 32'd0);
    for (int i = 0; i < 13; i++) begin
      cfg_wr(vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d_at_target", i), 32'(bus.at_target), 32'(vecs[i].exp_at));
    end

    // Reset while UPDATE is visiting ch2: its strobe must never appear.
    wait_cyc(3750);
    cfg_wr(3'd2, 32'd200000);
    cfg_wr(3'd0, 32'd102000);
    cfg_wr(3'd7, 32'd1);
    expect_wr(3801, 0, 32'd102000);
    wait_cyc(3801);
    check("sweep_busy", 32'(bus.busy), 32'd1);
    wait_cyc(3802);
    PRESET = 1'b1;
    exp_wr.delete();
    exp_dat.delete();
    for (int k = 0; k < NCH; k++) expect_wr(1 + k, k, 32'd150000);
    @(negedge PCLK);
    PRESET = 1'b0;
    check("abort_write", 32'(bus.servo_write), 32'd0);
    check("abort_data", bus.servo_data, 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd1);
    wait_cyc(6);
    check("reinit_busy", 32'(bus.busy), 32'd0);
    check("reinit_at_target", 32'(bus.at_target), 32'h1F);
    wait_cyc(20);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/servo_ramp_ctrl.md
SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 Parameter NCH, default 5, number of servo channels (one per finger).
REQ-002 Parameter PERIOD, default 2000000, PCLK cycles per servo frame.
REQ-003 Parameter PW_MIN, default 100000, minimum pulse width in PCLK cycles.
REQ-004 Parameter PW_MAX, default 200000, maximum pulse width in PCLK cycles.
REQ-005 Parameter PW_CENTER, default 150000, reset and initial pulse width.
REQ-006 Parameter STEP, default 2000, maximum pulse-width change per channel per frame.
REQ-007 Port PCLK  input  1  sole clock; all logic on its rising edge.
REQ-008 Port PRESET  input  1  reset, synchronous, active-high.
REQ-009 Port cfg_write  input  1  single-cycle write strobe; always accepted, no backpressure.
REQ-010 Port cfg_addr  input  3  0..NCH-1 = channel target; 7 = control; others ignored.
REQ-011 Port cfg_data  input  32  write data.
REQ-012 Port servo_write  output  NCH  one-hot per-channel write strobe to the PWM channel instances.
REQ-013 Port servo_data  output  32  pulse width shared by all channels, valid while any servo_write bit is high.
REQ-014 Port at_target  output  NCH  bit k high when current width of channel k equals its target.
REQ-015 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 Target write to channel k SHALL store cfg_data clamped to [PW_MIN, PW_MAX].
REQ-017 Control write SHALL set enable = cfg_data[0].
REQ-018 The frame counter SHALL count 0..PERIOD-1 and wrap, free-running regardless of enable; tick = (count == PERIOD-1).
REQ-019 FSM states SHALL be INIT, IDLE and UPDATE.
REQ-020 INIT: visit channels 0..NCH-1 one per cycle, issuing a write of PW_CENTER to each, then go to IDLE.
REQ-021 IDLE: on tick with enable=1 go to UPDATE with index 0; on tick with enable=0 stay in IDLE.
REQ-022 UPDATE: one channel per cycle, index 0..NCH-1, then return to IDLE.
REQ-023 In UPDATE, next = cur+min(STEP, target-cur) if cur<target, cur-min(STEP, cur-target) if cur>target, else cur.
REQ-024 In UPDATE, if next != cur then cur SHALL be updated and a write issued; otherwise no write is issued.
REQ-025 A write for the channel visited in cycle C SHALL appear as servo_write[k]=1 and servo_data=value in cycle C+1, for exactly one cycle.
REQ-026 Latency: for a tick in cycle T, the channel k strobe, if issued, SHALL occur in cycle T+2+k.
REQ-027 servo_write SHALL be at most one-hot; it SHALL be 0 whenever no write is issued, and servo_data SHALL then hold its last value.
REQ-028 Differences SHALL be computed at 32 bits unsigned without wrap, and cur SHALL never leave [PW_MIN, PW_MAX].
REQ-029 A target write to the channel being visited in the same cycle SHALL NOT affect that visit; it takes effect from the next frame.
REQ-030 A tick arriving while in INIT or UPDATE SHALL be ignored; the frame is skipped.
REQ-031 Clearing enable during UPDATE SHALL let the current sweep finish.

Reset
REQ-032 PRESET SHALL set all targets and cur to PW_CENTER, enable=1, counter=0, servo_write=0, servo_data=0, and state=INIT.
REQ-033 PRESET asserted mid-UPDATE SHALL abort the sweep, suppress any pending strobe, and restart in INIT once released.

Structure
REQ-034 Package servo_pkg SHALL hold the NCH/PERIOD/PW_* /STEP defaults, the control address constant (7) and the FSM state enum.
REQ-035 The frame counter SHALL be the sub-module servo_frame_timer (PCLK, PRESET, tick output).

Verification (bench: PERIOD=100, STEP=2000, NCH=5)
REQ-036 Release reset -> servo_write pulses 00001..10000 on 5 consecutive cycles with servo_data=150000 each; then busy=0.
REQ-037 Write ch2 target 156000 -> ch2 writes 152000, 154000, 156000 on three successive frames, at cycle T+4; then at_target[2]=1 and no further writes.
REQ-038 Write ch0 target 5000 -> stored target 100000; cur steps down by 2000 per frame; write ch0 target 999999 -> stored 200000.
REQ-039 Control write 0 -> no servo_write across 3 ticks, with cur held; control write 1 -> ramping resumes at the next tick.
REQ-040 Target write to ch1 in the cycle ch1 is visited -> that frame uses the old target; the new target applies next frame.
REQ-041 Assert PRESET during UPDATE at index 2 -> no strobe for ch2, then the INIT sequence of 5 writes of 150000.
